// File: rtl/apb_mst_pkg.sv
// Shared types and default widths for the APB config master.
// State encoding and command bundle used by the FIFO and the top.
package apb_mst_pkg;

  localparam int APB_MST_AW      = 12;
  localparam int APB_MST_DW      = 32;
  localparam int APB_MST_DEPTH   = 4;
  localparam int APB_MST_TIMEOUT = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_MST_AW-1:0] addr;
    logic [APB_MST_DW-1:0] wdata;
  } apb_mst_cmd_t;

  function automatic int apb_mst_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/apb_mst_cmd_fifo.sv
// Synchronous command FIFO; extra pointer bit separates full from empty.
// No bypass: a push while full is refused even if a pop happens.
module apb_mst_cmd_fifo
  import apb_mst_pkg::*;
#(
  parameter type T     = apb_mst_cmd_t,
  parameter int  DEPTH = APB_MST_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int PW = apb_mst_ptr_w(DEPTH) - 1;

  logic [PW:0] wptr;
  logic [PW:0] rptr;
  T            mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) &&
                   (wptr[PW-1:0] == rptr[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[PW-1:0]];

  // pointer update; wraps naturally through the extra bit
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (PW+1)'(1);
      if (do_pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/apb_cfg_master.sv
// APB3 initiator: queues commands, runs SETUP/ACCESS, returns responses.
// Optional ACCESS timeout enabled by defining APB_MST_TIMEOUT_EN.
module apb_cfg_master
  import apb_mst_pkg::*;
#(
  parameter int AW          = APB_MST_AW,
  parameter int DW          = APB_MST_DW,
  parameter int DEPTH       = APB_MST_DEPTH,
  parameter int TIMEOUT_CYC = APB_MST_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          busy,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  output logic          pwrite,
  output logic          psel,
  output logic          penable,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  apb_mst_state_e state;
  apb_mst_state_e state_nxt;

  cmd_t push_cmd;
  cmd_t head;
  logic full;
  logic empty;
  logic issue;
  logic done;
  logic rsp_free;
  logic timeout_hit;

  assign push_cmd = '{write: cmd_write,
                      addr:  cmd_addr,
                      wdata: cmd_wdata};

  assign cmd_ready = !full && !rst;
  assign rsp_free  = !rsp_valid || rsp_ready;
  assign psel      = (state != IDLE);
  assign penable   = (state == ACCESS);
  assign busy      = !empty || (state != IDLE) || rsp_valid;

  apb_mst_cmd_fifo #(
    .T     (cmd_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .wdata (push_cmd),
    .pop   (issue),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state; issue only when the response slot will be free
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && rsp_free) begin
          issue     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (pready || timeout_hit) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // APB address/data held from pop until the next pop
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
    end else if (issue) begin
      paddr  <= head.addr;
      pwdata <= head.wdata;
      pwrite <= head.write;
    end
  end

  // response register; held until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (done) begin
      rsp_valid   <= 1'b1;
      rsp_write   <= pwrite;
      rsp_rdata   <= (pwrite || timeout_hit) ? '0 : prdata;
      rsp_err     <= timeout_hit || pslverr;
      rsp_timeout <= timeout_hit;
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

`ifdef APB_MST_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] to_cnt;

  // ACCESS cycle counter; zero on entry, saturates at the limit
  always_ff @(posedge clk) begin
    if (rst || state != ACCESS)
      to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYC - 1))
      to_cnt <= to_cnt + TW'(1);
  end

  assign timeout_hit = (state == ACCESS) && !pready &&
                       (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cfg_master.sv
// Bench for apb_cfg_master with a small register-block slave model.
// Slave has RW regs at 0x000/0x004/0x008, self-clearing 0x00C.
module tb_apb_cfg_master;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          busy;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  always #5 clk = ~clk;

  apb_cfg_master #(
    .AW          (AW),
    .DW          (DW),
    .DEPTH       (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pwrite      (pwrite),
    .psel        (psel),
    .penable     (penable),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  // slave model
  logic [31:0] r0, r1, r2, cfg_cfg0;
  int          wcnt;
  int          stall;
  logic        hang;

  assign pready = psel && penable && (wcnt >= stall) && !hang;

  always_comb begin
    prdata  = '0;
    pslverr = (paddr >= 12'h010);
    case (paddr)
      12'h000: prdata = r0;
      12'h004: prdata = r1;
      12'h008: prdata = r2;
      default: prdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0 <= '0; r1 <= '0; r2 <= '0;
      cfg_cfg0 <= '0;
      wcnt <= 0;
    end else begin
      cfg_cfg0 <= '0;
      if (psel && penable && !pready) wcnt <= wcnt + 1;
      else                            wcnt <= 0;
      if (psel && penable && pready && pwrite) begin
        case (paddr)
          12'h000: r0 <= pwdata;
          12'h004: r1 <= pwdata;
          12'h008: r2 <= pwdata;
          12'h00C: cfg_cfg0 <= pwdata;
          default: ;
        endcase
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input logic w, input logic [11:0] a,
                      input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic wait_penable();
    int n = 0;
    while (!penable && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("penable_seen", {31'd0, penable}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    int          stall;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [9];

  logic        q_w   [5];
  logic [31:0] q_rd  [5];
  logic        q_err [5];

  initial begin
    int cnt;
    logic [11:0] a0;
    logic [31:0] d0;

    tbl[0] = '{1'b1, 12'h000, 32'h1234_5678, 0, 32'h0,         1'b0};
    tbl[1] = '{1'b0, 12'h000, 32'h0,         0, 32'h1234_5678, 1'b0};
    tbl[2] = '{1'b1, 12'h004, 32'hCAFE_F00D, 1, 32'h0,         1'b0};
    tbl[3] = '{1'b0, 12'h004, 32'h0,         2, 32'hCAFE_F00D, 1'b0};
    tbl[4] = '{1'b0, 12'h00C, 32'h0,         0, 32'h0,         1'b0};
    tbl[5] = '{1'b0, 12'h010, 32'h0,         0, 32'h0,         1'b1};
    tbl[6] = '{1'b1, 12'h7FC, 32'hDEAD_BEEF, 0, 32'h0,         1'b1};
    tbl[7] = '{1'b0, 12'h008, 32'h0,         1, 32'h0,         1'b0};
    tbl[8] = '{1'b1, 12'h00C, 32'h0000_00A5, 3, 32'h0,         1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    stall = 0; hang = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_psel",      {31'd0, psel},      32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // write 0xA5 to 0x00C with exact cycle timing
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 12'h00C; cmd_wdata = 32'hA5;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t1_c1_psel", {31'd0, psel}, 32'd0);
    @(negedge clk);
    chk("t1_c2_psel",    {31'd0, psel},    32'd1);
    chk("t1_c2_penable", {31'd0, penable}, 32'd0);
    chk("t1_c2_paddr",   {20'd0, paddr},   32'h00C);
    chk("t1_c2_pwdata",  pwdata,           32'hA5);
    chk("t1_c2_pwrite",  {31'd0, pwrite},  32'd1);
    @(negedge clk);
    chk("t1_c3_penable", {31'd0, penable}, 32'd1);
    @(negedge clk);
    chk("t1_c4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_c4_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("t1_c4_rsp_write", {31'd0, rsp_write}, 32'd1);
    chk("t1_c4_psel",      {31'd0, psel},      32'd0);
    chk("t1_c4_cfg0",      cfg_cfg0,           32'hA5);
    @(negedge clk);
    chk("t1_c5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t1_c5_cfg0",      cfg_cfg0,           32'h0);

    // table of single transfers
    for (int i = 0; i < 9; i++) begin
      stall = tbl[i].stall;
      push(tbl[i].w, tbl[i].a, tbl[i].d);
      wait_rsp($sformatf("v%0d_rsp", i));
      chk($sformatf("v%0d_rdata", i), rsp_rdata, tbl[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'd0, rsp_err},
          {31'd0, tbl[i].exp_err});
      chk($sformatf("v%0d_write", i), {31'd0, rsp_write},
          {31'd0, tbl[i].w});
      chk($sformatf("v%0d_tmo", i), {31'd0, rsp_timeout}, 32'd0);
      @(negedge clk);
      wait_idle();
    end
    stall = 0;

    // backpressure: five commands with responses stalled
    q_w[0] = 1'b1; q_rd[0] = 32'h0;         q_err[0] = 1'b0;
    q_w[1] = 1'b1; q_rd[1] = 32'h0;         q_err[1] = 1'b0;
    q_w[2] = 1'b0; q_rd[2] = 32'hAAAA_0001; q_err[2] = 1'b0;
    q_w[3] = 1'b0; q_rd[3] = 32'hBBBB_0002; q_err[3] = 1'b0;
    q_w[4] = 1'b0; q_rd[4] = 32'h0;         q_err[4] = 1'b1;
    rsp_ready = 1'b0;
    push(1'b1, 12'h000, 32'hAAAA_0001);
    push(1'b1, 12'h004, 32'hBBBB_0002);
    push(1'b0, 12'h000, 32'h0);
    push(1'b0, 12'h004, 32'h0);
    push(1'b0, 12'h010, 32'h0);
    chk("bp_full", {31'd0, cmd_ready}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (psel) cnt++;
      @(negedge clk);
    end
    chk("bp_no_issue", cnt, 0);
    chk("bp_held_rsp", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp($sformatf("bp%0d_rsp", k));
      chk($sformatf("bp%0d_write", k), {31'd0, rsp_write},
          {31'd0, q_w[k]});
      chk($sformatf("bp%0d_rdata", k), rsp_rdata, q_rd[k]);
      chk($sformatf("bp%0d_err", k), {31'd0, rsp_err},
          {31'd0, q_err[k]});
      @(negedge clk);
    end
    wait_idle();

    // wait states: APB outputs stable while pready low
    stall = 3;
    push(1'b1, 12'h008, 32'h5A5A_0F0F);
    wait_penable();
    a0 = paddr;
    d0 = pwdata;
    chk("ws_paddr0",  {20'd0, a0}, 32'h008);
    chk("ws_pwdata0", d0,          32'h5A5A_0F0F);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ws%0d_stable", k),
          {30'd0, psel, penable}, 32'd3);
      chk($sformatf("ws%0d_paddr", k),  {20'd0, paddr}, {20'd0, a0});
      chk($sformatf("ws%0d_pwdata", k), pwdata, d0);
      chk($sformatf("ws%0d_norsp", k),  {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    chk("ws_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ws_psel_drop", {31'd0, psel},      32'd0);
    @(negedge clk);
    wait_idle();
    stall = 0;

    // pready held low
    hang = 1'b1;
    push(1'b0, 12'h000, 32'h0);
    wait_penable();
`ifdef APB_MST_TIMEOUT_EN
    cnt = 0;
    while (penable && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("to_access_cycles", cnt, 8);
    chk("to_rsp_valid", {31'd0, rsp_valid},   32'd1);
    chk("to_rsp_err",   {31'd0, rsp_err},     32'd1);
    chk("to_rsp_tmo",   {31'd0, rsp_timeout}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata,            32'h0);
    chk("to_psel",      {31'd0, psel},        32'd0);
    @(negedge clk);
    wait_idle();
    push(1'b0, 12'h004, 32'h0);
    wait_penable();
`else
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (penable && !rsp_valid) cnt++;
      @(negedge clk);
    end
    chk("hang_wait", cnt, 30);
    push(1'b0, 12'h004, 32'h0);
`endif

    // reset in the middle of ACCESS
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_psel",      {31'd0, psel},      32'd0);
    chk("mr_penable",   {31'd0, penable},   32'd0);
    chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mr_busy",      {31'd0, busy},      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid || psel) cnt++;
      @(negedge clk);
    end
    chk("mr_quiet", cnt, 0);
    hang = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
